// File: rtl/l2_arbiter_rr.sv
// l2_arbiter_rr: round-robin arbiter from NUM_REQ L1 caches onto one L2 port.
// Optional macro ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority.
module l2_arbiter_rr #(
    parameter int NUM_REQ    = 2,
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_read,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_address,
    input  logic [NUM_REQ*LINE_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_resp,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    input  logic [LINE_WIDTH-1:0]            pmem_rdata,
    input  logic                             pmem_resp,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]            pmem_wdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [NUM_REQ-1:0]               service
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state;
    logic [NUM_REQ-1:0]      active;
    logic                    any_active;
    logic                    found;
    logic [IW-1:0]           grant_idx;
    logic [NUM_REQ-1:0]      grant_onehot;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic [LINE_WIDTH-1:0]   grant_wdata;
    logic                    grant_write;

`ifndef ARB_FIXED_PRIORITY_EN
    logic [IW-1:0]           winner;
    logic [IW-1:0]           last;
`endif

    assign active     = req_read | req_write;
    assign any_active = |active;

    // Winner search: fixed lowest index, or upward from last+1 with wrap.
    always_comb begin
        int idx;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && active[i]) begin
                grant_idx = IW'(i);
                found     = 1'b1;
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && active[idx]) begin
                grant_idx = IW'(idx);
                found     = 1'b1;
            end
        end
`endif
    end

    // Select the winning requester's address, line and command.
    always_comb begin
        grant_onehot            = '0;
        grant_onehot[grant_idx] = 1'b1;
        grant_addr  = req_address[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        grant_wdata = req_wdata[int'(grant_idx)*LINE_WIDTH +: LINE_WIDTH];
        grant_write = req_write[grant_idx];
    end

    // IDLE/BUSY controller; L2-facing outputs are registered and held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            service      <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            winner       <= '0;
            last         <= IW'(NUM_REQ - 1);
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_active) begin
                        state        <= BUSY;
                        pmem_address <= grant_addr;
                        pmem_wdata   <= grant_wdata;
                        pmem_write   <= grant_write;
                        pmem_read    <= ~grant_write;
                        service      <= grant_onehot;
`ifndef ARB_FIXED_PRIORITY_EN
                        winner       <= grant_idx;
`endif
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        state        <= IDLE;
                        pmem_address <= '0;
                        pmem_wdata   <= '0;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        service      <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
                        last         <= winner;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion goes only to the owner; stray responses in IDLE are dropped.
    assign req_resp  = service & {NUM_REQ{pmem_resp & (state == BUSY)}};
    assign req_rdata = pmem_rdata;

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// tb_l2_arbiter_rr: scoreboard bench for l2_arbiter_rr.
// Expected grants are queued when requests are driven.
module tb_l2_arbiter_rr;

    localparam int NR = 2;
    localparam int LW = 128;
    localparam int AW = 16;

    typedef struct {
        int             id;
        logic [AW-1:0]  addr;
        logic           wr;
        logic [LW-1:0]  wdata;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_read = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_address = '0;
    logic [NR*LW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_resp;
    logic [LW-1:0]     req_rdata;
    logic [LW-1:0]     pmem_rdata = '0;
    logic              pmem_resp = 1'b0;
    logic [AW-1:0]     pmem_address;
    logic [LW-1:0]     pmem_wdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [NR-1:0]     service;

    exp_t              sb[$];
    exp_t              cur;
    int                checks = 0;
    int                errors = 0;

    l2_arbiter_rr #(.NUM_REQ(NR), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .service(service)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [NR-1:0] onehot(input int id);
        logic [NR-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic push_exp(input int id, input logic [AW-1:0] a,
                            input logic w, input logic [LW-1:0] d);
        exp_t e;
        e.id = id; e.addr = a; e.wr = w; e.wdata = d;
        sb.push_back(e);
    endtask

    // Wait for the next L2 command and compare it with the queue head.
    task automatic wait_grant(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(pmem_read || pmem_write) && cyc < 20);
        checks++;
        if (!(pmem_read || pmem_write)) begin
            errors++;
            $display("FAIL grant_timeout: no pmem command after %0d cycles", cyc);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: unexpected grant service=%b", service);
            return;
        end
        cur = sb.pop_front();
        checks++;
        if (service !== onehot(cur.id)) begin
            errors++;
            $display("FAIL grant_service: got %b want %b", service, onehot(cur.id));
        end
        checks++;
        if (pmem_address !== cur.addr) begin
            errors++;
            $display("FAIL grant_addr: got %h want %h", pmem_address, cur.addr);
        end
        checks++;
        if (pmem_write !== cur.wr || pmem_read !== !cur.wr) begin
            errors++;
            $display("FAIL grant_cmd: got r=%b w=%b want w=%b", pmem_read, pmem_write, cur.wr);
        end
        if (cur.wr) begin
            checks++;
            if (pmem_wdata !== cur.wdata) begin
                errors++;
                $display("FAIL grant_wdata: got %h want %h", pmem_wdata, cur.wdata);
            end
        end
    endtask

    // Hold BUSY for dly cycles, then respond and check the completion.
    task automatic finish_txn(input int dly, input logic [LW-1:0] rd,
                              input logic [NR-1:0] drop);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            checks++;
            if (pmem_address !== cur.addr) begin
                errors++;
                $display("FAIL busy_addr: got %h want %h", pmem_address, cur.addr);
            end
        end
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        #1;
        checks++;
        if (req_resp !== onehot(cur.id)) begin
            errors++;
            $display("FAIL resp: got %b want %b", req_resp, onehot(cur.id));
        end
        checks++;
        if (req_rdata !== rd) begin
            errors++;
            $display("FAIL rdata: got %h want %h", req_rdata, rd);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        req_read  = req_read & ~drop;
        req_write = req_write & ~drop;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || service !== '0) begin
            errors++;
            $display("FAIL idle_after_resp: r=%b w=%b svc=%b want 0", pmem_read, pmem_write, service);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({pmem_read, pmem_write, service, req_resp} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: r=%b w=%b svc=%b resp=%b", pmem_read, pmem_write, service, req_resp);
        end
        checks++;
        if (pmem_address !== '0 || pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h want 0", pmem_address, pmem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || service !== '0) begin
            errors++;
            $display("FAIL idle_no_req: r=%b svc=%b want 0", pmem_read, service);
        end
    endtask

    task automatic test_single_read;
        int n;
        req_address[1*AW +: AW] = 16'h1230;
        req_read = 2'b10;
        push_exp(1, 16'h1230, 1'b0, '0);
        wait_grant(n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles want 1", n);
        end
        finish_txn(3, {16{8'hA5}}, 2'b10);
    endtask

    task automatic test_simultaneous;
        int n;
        req_address[0 +: AW]  = 16'h1000;
        req_address[AW +: AW] = 16'h2000;
        req_read = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            push_exp(0, 16'h1000, 1'b0, '0);
`else
            if (i % 2 == 0) push_exp(0, 16'h1000, 1'b0, '0);
            else            push_exp(1, 16'h2000, 1'b0, '0);
`endif
        end
        for (int i = 0; i < 4; i++) begin
            wait_grant(n);
            checks++;
            if (n !== 1) begin
                errors++;
                $display("FAIL rr_gap txn%0d: got %0d cycles want 1", i, n);
            end
            finish_txn(2, {LW{1'b0}} | LW'(i + 1), (i == 3) ? 2'b11 : 2'b00);
        end
    endtask

    task automatic test_write_with_read;
        int n;
        logic [LW-1:0] d;
        d = {16'hDEAD, 96'h0123_4567_89AB_CDEF_0011_2233, 16'hBEEF};
        req_address[0 +: AW] = 16'h0040;
        req_wdata[0 +: LW]   = d;
        req_read  = 2'b01;
        req_write = 2'b01;
        push_exp(0, 16'h0040, 1'b1, d);
        wait_grant(n);
        finish_txn(2, '0, 2'b01);
    endtask

    task automatic test_busy_change;
        int n;
        req_address[0 +: AW] = 16'h0040;
        req_read = 2'b01;
        push_exp(0, 16'h0040, 1'b0, '0);
        wait_grant(n);
        req_address[0 +: AW] = 16'hFFFE;
        req_wdata[0 +: LW]   = '1;
        finish_txn(3, {8{16'h5A5A}}, 2'b01);
    endtask

    task automatic test_reset_mid;
        int n;
        req_address[0 +: AW] = 16'h0100;
        req_read = 2'b01;
        push_exp(0, 16'h0100, 1'b0, '0);
        wait_grant(n);
        #2;
        rst = 1'b1;
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || service !== '0) begin
            errors++;
            $display("FAIL rst_async: r=%b svc=%b want 0", pmem_read, service);
        end
        checks++;
        if (req_resp !== '0) begin
            errors++;
            $display("FAIL rst_resp: got %b want 0", req_resp);
        end
        pmem_resp = 1'b0;
        req_read  = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        req_address[0 +: AW]  = 16'h0200;
        req_address[AW +: AW] = 16'h0300;
        req_read = 2'b11;
        push_exp(0, 16'h0200, 1'b0, '0);
        wait_grant(n);
        finish_txn(1, '1, 2'b11);
    endtask

    task automatic test_stray_resp;
        int n;
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (req_resp !== '0) begin
            errors++;
            $display("FAIL stray_resp: got %b want 0", req_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if (pmem_read !== 1'b0 || service !== '0) begin
            errors++;
            $display("FAIL stray_state: r=%b svc=%b want 0", pmem_read, service);
        end
        req_address[AW +: AW] = 16'h0777;
        req_read = 2'b10;
        push_exp(1, 16'h0777, 1'b0, '0);
        wait_grant(n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL stray_latency: got %0d cycles want 1", n);
        end
        finish_txn(1, '0, 2'b10);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_with_read();
        test_busy_change();
        test_reset_mid();
        test_stray_resp();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected grants unseen", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
